seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Receive side of the 7-segment display interface. Snoops a time-multiplexed display bus (segment lines plus one-hot digit select) and decodes each digit's pattern back to a 4-bit hex value. Accepts a pattern only after it has been stable for a configurable number of cycles. Assembles one word per complete scan frame and hands it off on a valid/ready interface. Used for display loop-back self-test and for debug capture of the digit bus.

Parameters:
NDIGITS, 4, number of multiplexed digits (>=1)
STABLE_CYCLES, 4, consecutive identical sampled cycles required to accept a pattern (>=1)
CW, $clog2(STABLE_CYCLES+1), run-counter width (derived, localparam)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
seg  input  7  segment lines, active-high, bit6=a ... bit0=g
sel  input  NDIGITS  digit enables, active-high, legal only when one-hot
value  output  4*NDIGITS  decoded frame; digit i occupies bits [4i+3:4i]
blank_mask  output  NDIGITS  bit i set: digit i showed all-off (value nibble 0)
err_mask  output  NDIGITS  bit i set: digit i showed an illegal pattern (value nibble 0)
out_valid  output  1  frame word available
out_ready  input  1  consumer accepts the word when high with out_valid
overrun  output  1  sticky: a frame was overwritten before it was consumed

Behaviour:
- Reset (async assert, sync release): all outputs 0; sample regs, run counter, shadow regs and captured mask cleared.
- Stage 1: seg and sel are registered every cycle into seg_q and sel_q. There is no other input filtering.
- Run counter, evaluated on seg_q/sel_q:
  - Increments, saturating at STABLE_CYCLES, while seg_q/sel_q equal the previous cycle's values and sel_q is one-hot.
  - Otherwise reloads to 1 if sel_q is one-hot, or to 0 if not.
  - Zero or multiple bits set in sel_q means no capture.
- Acceptance happens once per run, in the cycle the counter first equals STABLE_CYCLES. That cycle:
  - writes the digit's shadow nibble, blank bit and err bit;
  - sets the digit's bit in the captured mask.
- Latency: inputs constant from cycle t give a shadow update visible at t+STABLE_CYCLES+1.
- Decode:
  - Patterns 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111 decode to 0..F.
  - 0000000 decodes to blank.
  - Anything else is err.
- Re-acceptance of a digit already captured in the current frame overwrites its shadow. The captured mask is unchanged.
- Frame complete: the edge where the captured mask becomes all-ones.
  - Shadows are copied to value/blank_mask/err_mask.
  - out_valid is set.
  - The captured mask is cleared.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_valid clears after a transfer unless a frame completes in the same cycle.
  - Outputs hold stable while out_valid && !out_ready, except on overrun.
- Overrun: frame completes while out_valid && !out_ready. Outputs are replaced by the new frame, out_valid stays 1, and overrun sets. overrun clears only on reset.
- Simultaneous transfer and frame complete: new word loaded, out_valid stays 1, no overrun.
- NDIGITS=1: every acceptance completes a frame.
- Reset mid-run: the partial frame is discarded.

Decomposition:
- Package seg_pkg holds:
  - the 7-bit pattern constants SEG_HEX_0..SEG_HEX_F and SEG_BLANK, shared with the encoder side;
  - a seg_pattern_t typedef.
- One sub-module, seg_pattern_decode (combinational):
  - input: 7-bit pattern;
  - outputs: 4-bit value, blank, err.
- The top level holds the sample regs, run counter, shadows, captured mask and handshake.

Test Plan:
- NDIGITS=4, S=4; hold each sel one-hot (0001, 0010, 0100, 1000) for 6 cycles with patterns for 1, 2, 3, 4 -> out_valid=1 after last digit accepted; value=16'h4321; masks 0.
- Digit 0 pattern held only 3 cycles, then held 4 cycles -> accepted only on the 4-cycle run; no capture from the 3-cycle run.
- sel=0011 for 10 cycles, then sel=0000 -> no acceptance, captured mask unchanged, out_valid stays 0.
- Digit 2 driven 0000000, digit 3 driven 1010101 -> blank_mask=4'b0100, err_mask=4'b1000, nibbles 2 and 3 = 0.
- Two complete frames (h1111, then h2222) with out_ready=0 -> value=16'h2222, out_valid=1, overrun=1. Then out_ready=1 for 1 cycle -> out_valid=0, overrun remains 1.
- rst_n low for 1 cycle after 3 digits captured, then capture digit 3 only -> no out_valid, all outputs 0.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared 7-segment definitions for the display encoder and the scan decoder.
// Bit order of a pattern: bit6 = a, bit5 = b, ... bit0 = g. A set bit means
// the segment is lit.
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_HEX_0 = 7'b1111110;
    localparam seg_pattern_t SEG_HEX_1 = 7'b0110000;
    localparam seg_pattern_t SEG_HEX_2 = 7'b1101101;
    localparam seg_pattern_t SEG_HEX_3 = 7'b1111001;
    localparam seg_pattern_t SEG_HEX_4 = 7'b0110011;
    localparam seg_pattern_t SEG_HEX_5 = 7'b1011011;
    localparam seg_pattern_t SEG_HEX_6 = 7'b1011111;
    localparam seg_pattern_t SEG_HEX_7 = 7'b1110000;
    localparam seg_pattern_t SEG_HEX_8 = 7'b1111111;
    localparam seg_pattern_t SEG_HEX_9 = 7'b1111011;
    localparam seg_pattern_t SEG_HEX_A = 7'b1110111;
    localparam seg_pattern_t SEG_HEX_B = 7'b0011111;
    localparam seg_pattern_t SEG_HEX_C = 7'b1001110;
    localparam seg_pattern_t SEG_HEX_D = 7'b0111101;
    localparam seg_pattern_t SEG_HEX_E = 7'b1001111;
    localparam seg_pattern_t SEG_HEX_F = 7'b1000111;
    localparam seg_pattern_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder_if
// Bundles the snooped display bus and the frame hand-off of seg_scan_decoder.
//   seg        : segment lines (bit6 = a ... bit0 = g), active-high
//   sel        : one-hot digit enables
//   value      : decoded frame, digit i at [4i+3:4i]
//   blank_mask : digit showed all segments off
//   err_mask   : digit showed an unrecognised pattern
//   out_valid  : frame word available
//   out_ready  : consumer accepts the word
//   overrun    : sticky, a frame was replaced before it was consumed
//
// Handshake: a word moves when out_valid && out_ready are both high at a rising
// clock edge. While out_valid is high and out_ready low, value/blank_mask/
// err_mask hold, except when a newer frame overwrites them (overrun sets).
// The slave modport is the decoder; the master modport is the display side
// plus the consumer.
// -----------------------------------------------------------------------------
interface seg_scan_decoder_if #(
    parameter int NDIGITS = 4
);
    import seg_pkg::*;

    seg_pattern_t             seg;
    logic [NDIGITS-1:0]       sel;
    logic [4*NDIGITS-1:0]     value;
    logic [NDIGITS-1:0]       blank_mask;
    logic [NDIGITS-1:0]       err_mask;
    logic                     out_valid;
    logic                     out_ready;
    logic                     overrun;

    modport slave (
        input  seg,
        input  sel,
        input  out_ready,
        output value,
        output blank_mask,
        output err_mask,
        output out_valid,
        output overrun
    );

    modport master (
        output seg,
        output sel,
        output out_ready,
        input  value,
        input  blank_mask,
        input  err_mask,
        input  out_valid,
        input  overrun
    );

endinterface

// File: rtl/seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_pattern_decode
// Combinational 7-segment pattern to hex decoder.
//   pattern_i : 7-bit segment pattern
//   value_o   : hex value 0..F (0 when blank or illegal)
//   blank_o   : pattern was all segments off
//   err_o     : pattern is not a hex digit and not blank
// -----------------------------------------------------------------------------
module seg_pattern_decode
    import seg_pkg::*;
(
    input  seg_pattern_t pattern_i,
    output logic [3:0]   value_o,
    output logic         blank_o,
    output logic         err_o
);

    always_comb begin
        value_o = 4'h0;
        blank_o = 1'b0;
        err_o   = 1'b0;
        case (pattern_i)
            SEG_HEX_0: value_o = 4'h0;
            SEG_HEX_1: value_o = 4'h1;
            SEG_HEX_2: value_o = 4'h2;
            SEG_HEX_3: value_o = 4'h3;
            SEG_HEX_4: value_o = 4'h4;
            SEG_HEX_5: value_o = 4'h5;
            SEG_HEX_6: value_o = 4'h6;
            SEG_HEX_7: value_o = 4'h7;
            SEG_HEX_8: value_o = 4'h8;
            SEG_HEX_9: value_o = 4'h9;
            SEG_HEX_A: value_o = 4'hA;
            SEG_HEX_B: value_o = 4'hB;
            SEG_HEX_C: value_o = 4'hC;
            SEG_HEX_D: value_o = 4'hD;
            SEG_HEX_E: value_o = 4'hE;
            SEG_HEX_F: value_o = 4'hF;
            SEG_BLANK: blank_o = 1'b1;
            default:   err_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Snoops a time-multiplexed 7-segment bus and rebuilds one hex word per
// complete scan frame. A digit is accepted once its pattern and select have
// been stable for STABLE_CYCLES sampled cycles; a frame completes when every
// digit has been accepted at least once since the last frame.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_decoder_if slave (display bus in, frame hand-off out)
// -----------------------------------------------------------------------------
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_decoder_if.slave    bus
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] RUN_ONE = CW'(1);

    // Input samples and the previous sample used for the stability compare.
    seg_pattern_t          seg_q, seg_p_q;
    logic [NDIGITS-1:0]    sel_q, sel_p_q;

    logic [CW-1:0]         run_q, run_d;
    logic                  accept_q, accept_d;

    logic [4*NDIGITS-1:0]  shadow_val_q, shadow_val_d;
    logic [NDIGITS-1:0]    shadow_blank_q, shadow_blank_d;
    logic [NDIGITS-1:0]    shadow_err_q, shadow_err_d;
    logic [NDIGITS-1:0]    cap_q, cap_d, cap_next;

    logic [4*NDIGITS-1:0]  value_q, value_d;
    logic [NDIGITS-1:0]    blank_q, blank_d;
    logic [NDIGITS-1:0]    err_q, err_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic                  same_sample;
    logic                  sel_onehot;
    logic                  frame_done;
    logic [3:0]            dec_value;
    logic                  dec_blank;
    logic                  dec_err;

    // During the acceptance cycle the previous-sample registers hold the
    // pattern that was counted as stable, so decode from those.
    seg_pattern_decode u_decode (
        .pattern_i (seg_p_q),
        .value_o   (dec_value),
        .blank_o   (dec_blank),
        .err_o     (dec_err)
    );

    // Run counter and one-shot acceptance.
    always_comb begin
        same_sample = (seg_q == seg_p_q) && (sel_q == sel_p_q);
        sel_onehot  = $onehot(sel_q);
        run_d       = run_q;
        if (same_sample && sel_onehot) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
        end else begin
            run_d = sel_onehot ? RUN_ONE : '0;
        end
        // Accept only on the step into RUN_MAX; a saturated run that simply
        // stays at RUN_MAX is not a new acceptance.
        accept_d = (run_d == RUN_MAX) &&
                   !(same_sample && sel_onehot && (run_q == RUN_MAX));
    end

    // Shadow update, captured mask and frame completion.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        shadow_err_d   = shadow_err_q;
        cap_next       = cap_q;
        if (accept_q) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if (sel_p_q[i]) begin
                    shadow_val_d[4*i +: 4] = dec_value;
                    shadow_blank_d[i]      = dec_blank;
                    shadow_err_d[i]        = dec_err;
                end
            end
            cap_next = cap_q | sel_p_q;
        end
        frame_done = accept_q && (&cap_next);
        cap_d      = frame_done ? '0 : cap_next;
    end

    // Output word and handshake.
    always_comb begin
        value_d   = value_q;
        blank_d   = blank_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (frame_done) begin
            value_d = shadow_val_d;
            blank_d = shadow_blank_d;
            err_d   = shadow_err_d;
            valid_d = 1'b1;
            if (valid_q && !bus.out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q          <= '0;
            sel_q          <= '0;
            seg_p_q        <= '0;
            sel_p_q        <= '0;
            run_q          <= '0;
            accept_q       <= 1'b0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            shadow_err_q   <= '0;
            cap_q          <= '0;
            value_q        <= '0;
            blank_q        <= '0;
            err_q          <= '0;
            valid_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            seg_q          <= bus.seg;
            sel_q          <= bus.sel;
            seg_p_q        <= seg_q;
            sel_p_q        <= sel_q;
            run_q          <= run_d;
            accept_q       <= accept_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_err_q   <= shadow_err_d;
            cap_q          <= cap_d;
            value_q        <= value_d;
            blank_q        <= blank_d;
            err_q          <= err_d;
            valid_q        <= valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.blank_mask = blank_q;
    assign bus.err_mask   = err_q;
    assign bus.out_valid  = valid_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int W  = 25;   // {overrun, err_mask, blank_mask, value}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.NDIGITS(ND)) bus ();

    seg_scan_decoder #(.NDIGITS(ND), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0]   hex_pat [16];
    logic [W-1:0] exp_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input logic ovr, input logic [3:0] err,
                                             input logic [3:0] blank, input logic [15:0] val);
        return {ovr, err, blank, val};
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge; inputs set here are
    // sampled on the next 'cycles' rising edges.
    task automatic drive_digit(input int idx, input logic [6:0] pat, input int cycles);
        bus.sel = ND'(1) << idx;
        bus.seg = pat;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input logic [ND-1:0] sel, input logic [6:0] pat, input int cycles);
        bus.sel = sel;
        bus.seg = pat;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        drive_raw('0, 7'b0, cycles);
    endtask

    // Digits 0..3 with hex values h0..h3, each held 6 cycles.
    task automatic drive_frame(input logic [3:0] h0, input logic [3:0] h1,
                               input logic [3:0] h2, input logic [3:0] h3);
        drive_digit(0, hex_pat[h0], 6);
        drive_digit(1, hex_pat[h1], 6);
        drive_digit(2, hex_pat[h2], 6);
        drive_digit(3, hex_pat[h3], 6);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            logic [W-1:0] got;
            got = {bus.overrun, bus.err_mask, bus.blank_mask, bus.value};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", got);
            end else begin
                logic [W-1:0] exp;
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL frame_word: got %h expected %h", got, exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        hex_pat = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        bus.seg       = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_value",   32'(bus.value),      32'h0);
        check("rst_blank",   32'(bus.blank_mask), 32'h0);
        check("rst_err",     32'(bus.err_mask),   32'h0);
        check("rst_valid",   32'(bus.out_valid),  32'h0);
        check("rst_overrun", 32'(bus.overrun),    32'h0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(2);

        // Basic frame 4321.
        exp_q.push_back(mk_word(1'b0, 4'h0, 4'h0, 16'h4321));
        drive_frame(4'h1, 4'h2, 4'h3, 4'h4);
        idle(4);

        // Digit 0 held 3 cycles (pattern 7) must not capture; held 4 cycles
        // (pattern 5) must.
        exp_q.push_back(mk_word(1'b0, 4'h0, 4'h0, 16'hCBA5));
        drive_digit(0, hex_pat[7], 3);
        idle(1);
        drive_digit(1, hex_pat[4'hA], 6);
        drive_digit(2, hex_pat[4'hB], 6);
        drive_digit(3, hex_pat[4'hC], 6);
        idle(3);
        check("short_run_no_frame", 32'(bus.out_valid), 32'h0);
        drive_digit(0, hex_pat[5], 4);
        idle(4);

        // Non-one-hot select captures nothing.
        exp_q.push_back(mk_word(1'b0, 4'h0, 4'h0, 16'hDE96));
        drive_digit(1, hex_pat[9], 6);
        drive_digit(2, hex_pat[4'hE], 6);
        drive_digit(3, hex_pat[4'hD], 6);
        drive_raw(4'b0011, hex_pat[8], 10);
        idle(3);
        check("multi_sel_no_frame", 32'(bus.out_valid), 32'h0);
        drive_digit(0, hex_pat[6], 6);
        idle(4);

        // Blank and illegal patterns.
        exp_q.push_back(mk_word(1'b0, 4'b1000, 4'b0100, 16'h0080));
        drive_digit(0, hex_pat[0], 6);
        drive_digit(1, hex_pat[8], 6);
        drive_digit(2, 7'b0000000, 6);
        drive_digit(3, 7'b1010101, 6);
        idle(4);

        // Overrun: two frames with no consumer.
        bus.out_ready = 1'b0;
        drive_frame(4'h1, 4'h1, 4'h1, 4'h1);
        idle(3);
        check("ovr_first_valid",   32'(bus.out_valid), 32'h1);
        check("ovr_first_overrun", 32'(bus.overrun),   32'h0);
        check("ovr_first_value",   32'(bus.value),     32'h1111);
        exp_q.push_back(mk_word(1'b1, 4'h0, 4'h0, 16'h2222));
        drive_frame(4'h2, 4'h2, 4'h2, 4'h2);
        idle(3);
        check("ovr_value",   32'(bus.value),     32'h2222);
        check("ovr_valid",   32'(bus.out_valid), 32'h1);
        check("ovr_overrun", 32'(bus.overrun),   32'h1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("ovr_after_xfer_valid",   32'(bus.out_valid), 32'h0);
        check("ovr_after_xfer_overrun", 32'(bus.overrun),   32'h1);

        // Reset mid-frame discards the partial frame.
        bus.out_ready = 1'b1;
        drive_digit(0, hex_pat[3], 6);
        drive_digit(1, hex_pat[3], 6);
        drive_digit(2, hex_pat[3], 6);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_digit(3, hex_pat[3], 6);
        idle(4);
        check("midrst_valid",   32'(bus.out_valid),  32'h0);
        check("midrst_value",   32'(bus.value),      32'h0);
        check("midrst_blank",   32'(bus.blank_mask), 32'h0);
        check("midrst_err",     32'(bus.err_mask),   32'h0);
        check("midrst_overrun", 32'(bus.overrun),    32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
